// File: rtl/usb_tx_pkg.sv
// Shared types, default parameters and width helper for the USB TX timing blocks.
package usb_tx_pkg;

    typedef enum logic {TXT_IDLE, TXT_ACTIVE} txt_state_t;

    localparam int TX_CLKS_PER_BIT  = 8;
    localparam int TX_BITS_PER_BYTE = 8;
    localparam int TX_MAX_BYTES     = 32;

    // Counter width for a modulus of n, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/usb_tx_frame_timer_sr_counter.sv
// Wrapping up-counter with synchronous active-high reset, clear and enable.
module sr_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    assign at_max = (count == WIDTH'(MAX));

    // Count up on enable and wrap after MAX; reset and clear take priority.
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (rst || clear) begin
            count <= '0;
        end else if (en) begin
            count <= at_max ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/usb_tx_frame_timer.sv
// Transmit bit/byte/frame strobe generator with stuffing, hold and abort.
module usb_tx_frame_timer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = TX_CLKS_PER_BIT,
    parameter int BITS_PER_BYTE = TX_BITS_PER_BYTE,
    parameter int MAX_BYTES     = TX_MAX_BYTES
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               start,
    input  logic [$clog2(MAX_BYTES+1)-1:0]     num_bytes,
    input  logic                               hold,
    input  logic                               stuff_req,
    input  logic                               abort,
    output logic                               busy,
    output logic                               bit_tick,
    output logic                               stuff_tick,
    output logic                               byte_done,
    output logic                               frame_done,
    output logic [cnt_w(BITS_PER_BYTE)-1:0]    bit_idx,
    output logic [$clog2(MAX_BYTES+1)-1:0]     byte_idx
);

    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam int BW = cnt_w(BITS_PER_BYTE);
    localparam int LW = $clog2(MAX_BYTES + 1);

    txt_state_t     state;
    logic [LW-1:0]  len;
    logic           active;

    logic [CW-1:0]  clk_cnt;
    logic           clk_at_max;
    logic [BW-1:0]  bit_cnt;
    logic           bit_at_max;
    logic [LW-1:0]  byte_cnt;
    logic           byte_at_max;

    logic           tick;
    logic           counted;
    logic           byte_end;
    logic           frame_end;
    logic           cnt_clear;

    assign active  = (state == TXT_ACTIVE);
    assign tick    = active & ~hold & clk_at_max;
    assign counted = tick & ~stuff_req;
    assign byte_end = counted & bit_at_max;
    // byte_cnt never exceeds len-1, so reaching MAX_BYTES-1 implies the last byte;
    // the extra term only bounds the count if len were ever out of range.
    assign frame_end = byte_end & ((byte_cnt == len - LW'(1)) | byte_at_max);
    // Counters sit at zero in IDLE and are cleared on the edge that leaves ACTIVE.
    assign cnt_clear = ~active | abort | frame_end;

    sr_counter #(.WIDTH(CW), .MAX(CLKS_PER_BIT - 1)) u_clk_cnt (
        .clk    (clk),
        .rst    (n_rst),
        .clear  (cnt_clear),
        .en     (active & ~hold),
        .count  (clk_cnt),
        .at_max (clk_at_max)
    );

    sr_counter #(.WIDTH(BW), .MAX(BITS_PER_BYTE - 1)) u_bit_cnt (
        .clk    (clk),
        .rst    (n_rst),
        .clear  (cnt_clear),
        .en     (counted),
        .count  (bit_cnt),
        .at_max (bit_at_max)
    );

    sr_counter #(.WIDTH(LW), .MAX(MAX_BYTES - 1)) u_byte_cnt (
        .clk    (clk),
        .rst    (n_rst),
        .clear  (cnt_clear),
        .en     (byte_end),
        .count  (byte_cnt),
        .at_max (byte_at_max)
    );

    // Frame sequencing: accept a non-empty start in IDLE, leave on abort or last byte.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state <= TXT_IDLE;
            len   <= '0;
        end else begin
            case (state)
                TXT_IDLE: begin
                    if (start && !abort && num_bytes != '0) begin
                        state <= TXT_ACTIVE;
                        len   <= (num_bytes > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : num_bytes;
                    end
                end
                TXT_ACTIVE: begin
                    if (abort || frame_end) begin
                        state <= TXT_IDLE;
                        len   <= '0;
                    end
                end
                default: state <= TXT_IDLE;
            endcase
        end
    end

    // All outputs are forced low during the reset cycle, even mid-frame.
    assign busy       = active & ~n_rst;
    assign bit_tick   = tick & ~n_rst;
    assign stuff_tick = tick & stuff_req & ~n_rst;
    assign byte_done  = byte_end & ~n_rst;
    assign frame_done = frame_end & ~n_rst;
    assign bit_idx    = n_rst ? '0 : bit_cnt;
    assign byte_idx   = n_rst ? '0 : byte_cnt;

endmodule
